// File: rtl/bcd_operand_entry_if.sv
// rtl/bcd_operand_entry_if.sv - keypad/ALU handshake bundle for the BCD operand entry block
//
// Purpose: groups the keypad strobe, ALU handshake and operand outputs.
// Ports (signals):
//   key_valid, key_code      keypad strobe and code (0-9 digit, 10 ADD, 11 SUB, 14 CLEAR, 15 ENTER)
//   alu_done                 ALU result-ready strobe
//   operand_a, operand_b     BCD operands, digit 2 in the top nibble
//   op_sel                   latched operator, 0 = ADD, 1 = SUB
//   start, busy              ALU request pulse and in-flight indication
//   display_value            operand currently being edited
// Modports: master = keypad/ALU side, slave = entry block.
interface bcd_operand_entry_if #(
  parameter int NUM_DIGITS = 3
);
  localparam int W = 4 * NUM_DIGITS;

  logic         key_valid;
  logic [3:0]   key_code;
  logic         alu_done;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         op_sel;
  logic         start;
  logic         busy;
  logic [W-1:0] display_value;

  modport master (
    output key_valid, key_code, alu_done,
    input  operand_a, operand_b, op_sel, start, busy, display_value
  );

  modport slave (
    input  key_valid, key_code, alu_done,
    output operand_a, operand_b, op_sel, start, busy, display_value
  );
endinterface

// File: rtl/bcd_operand_entry.sv
// rtl/bcd_operand_entry.sv - keypad-driven BCD operand and operator entry for the ALU
//
// Purpose: collects two NUM_DIGITS BCD operands and an operator from keypad
// strobes, issues a one-cycle start to the ALU and holds everything stable
// until alu_done.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    bcd_operand_entry_if.slave (key_valid, key_code, alu_done in;
//          operand_a, operand_b, op_sel, start, busy, display_value out)
module bcd_operand_entry #(
  parameter int NUM_DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  bcd_operand_entry_if.slave  bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd14;
  localparam logic [3:0] KEY_ENTER = 4'd15;

  typedef enum logic [1:0] {
    ENTER_A     = 2'd0,
    ENTER_B     = 2'd1,
    ISSUE       = 2'd2,
    WAIT_RESULT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  operand_a_q, operand_a_d;
  logic [W-1:0]  operand_b_q, operand_b_d;
  logic [W-1:0]  display_q, display_d;
  logic          op_sel_q, op_sel_d;
  logic          start_q, start_d;
  // Set when a result has just returned: operand_a still shows the old
  // value, but the first digit typed starts a fresh operand.
  logic          fresh_q, fresh_d;

  logic          is_digit;
  logic          room;
  logic [W-1:0]  a_base;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    op_sel_d    = op_sel_q;
    fresh_d     = fresh_q;
    is_digit    = (bus.key_code <= 4'd9);
    room        = (count_q < CW'(NUM_DIGITS));
    a_base      = fresh_q ? '0 : operand_a_q;

    case (state_q)
      ENTER_A: begin
        if (bus.key_valid) begin
          if (is_digit) begin
            if (room) begin
              operand_a_d = {a_base[W-5:0], bus.key_code};
              count_d     = count_q + 1'b1;
              fresh_d     = 1'b0;
            end
          end else if (bus.key_code == KEY_ADD || bus.key_code == KEY_SUB) begin
            // Operator on an untouched result chains it as operand A.
            op_sel_d    = (bus.key_code == KEY_SUB);
            operand_b_d = '0;
            count_d     = '0;
            fresh_d     = 1'b0;
            state_d     = ENTER_B;
          end else if (bus.key_code == KEY_CLEAR) begin
            operand_a_d = '0;
            operand_b_d = '0;
            op_sel_d    = 1'b0;
            count_d     = '0;
            fresh_d     = 1'b0;
          end
        end
      end
      ENTER_B: begin
        if (bus.key_valid) begin
          if (is_digit) begin
            if (room) begin
              operand_b_d = {operand_b_q[W-5:0], bus.key_code};
              count_d     = count_q + 1'b1;
            end
          end else if (bus.key_code == KEY_ADD || bus.key_code == KEY_SUB) begin
            op_sel_d = (bus.key_code == KEY_SUB);
          end else if (bus.key_code == KEY_CLEAR) begin
            operand_a_d = '0;
            operand_b_d = '0;
            op_sel_d    = 1'b0;
            count_d     = '0;
            state_d     = ENTER_A;
          end else if (bus.key_code == KEY_ENTER) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (bus.alu_done) begin
          state_d = ENTER_A;
          count_d = '0;
          fresh_d = 1'b1;
        end
      end
      default: begin
        state_d = ENTER_A;
      end
    endcase

    // Registered outputs are computed from next-state values so they line
    // up with state_q in the cycle they are seen.
    start_d   = (state_d == ISSUE);
    display_d = (state_d == ENTER_A) ? operand_a_d : operand_b_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ENTER_A;
      count_q     <= '0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      display_q   <= '0;
      op_sel_q    <= 1'b0;
      start_q     <= 1'b0;
      fresh_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      display_q   <= display_d;
      op_sel_q    <= op_sel_d;
      start_q     <= start_d;
      fresh_q     <= fresh_d;
    end
  end

  assign bus.operand_a     = operand_a_q;
  assign bus.operand_b     = operand_b_q;
  assign bus.op_sel        = op_sel_q;
  assign bus.start         = start_q;
  assign bus.display_value = display_q;
  assign bus.busy          = (state_q == ISSUE) || (state_q == WAIT_RESULT);
endmodule

// File: doc/bcd_operand_entry.md
BCD_OPERAND_ENTRY -- requirements
Module: bcd_operand_entry

Interface
REQ-001 Parameter: NUM_DIGITS, 3, number of BCD digits per operand; fixed at 3 for the ALU; operand width is 4*NUM_DIGITS = 12.
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset; the top level drives it from the inverted debounced resetPulse.
REQ-004 Port: key_valid  input  1  single-cycle strobe; key_code is valid in that cycle.
REQ-005 Port: key_code  input  4  0-9 digit; 10 ADD; 11 SUB; 14 CLEAR; 15 ENTER; 12 and 13 are reserved.
REQ-006 Port: alu_done  input  1  single-cycle strobe from the ALU when its result is ready.
REQ-007 Port: operand_a  output  12  BCD operand A; digit 2 in [11:8], digit 0 in [3:0].
REQ-008 Port: operand_b  output  12  BCD operand B, same layout as operand_a.
REQ-009 Port: op_sel  output  1  latched operator; 0 = ADD, 1 = SUB.
REQ-010 Port: start  output  1  single-cycle request to the ALU.
REQ-011 Port: busy  output  1  high while in ISSUE or WAIT_RESULT.
REQ-012 Port: display_value  output  12  operand currently being edited, for the seven-segment driver.

Function
REQ-013 FSM states SHALL be ENTER_A, ENTER_B, ISSUE and WAIT_RESULT, registered; a key event is a cycle with key_valid=1.
REQ-014 Digit key, edit state (ENTER_A or ENTER_B), digit count < NUM_DIGITS: the edited operand SHALL be updated as {operand[7:0], key_code} and the count incremented.
REQ-015 Digit key with count = NUM_DIGITS: SHALL be ignored; no change to the operand or the count.
REQ-016 A leading 0 digit SHALL count toward NUM_DIGITS.
REQ-017 ADD/SUB in ENTER_A: latch op_sel, clear operand_b, clear the count, and move to ENTER_B next cycle; an empty A is 000.
REQ-018 ADD/SUB in ENTER_B: overwrite op_sel and stay in ENTER_B; operand_b and the count are unchanged.
REQ-019 ENTER in ENTER_B: move to ISSUE; ENTER in ENTER_A: ignored.
REQ-020 ISSUE: start=1 for exactly one cycle, then move unconditionally to WAIT_RESULT.
REQ-021 WAIT_RESULT: all key events, CLEAR included, are ignored; on alu_done=1, move to ENTER_A with count cleared.
REQ-022 ENTER_A after alu_done: operands keep their values until the first digit, which SHALL clear operand_a to 000 before shifting, giving result 00d.
REQ-023 CLEAR in ENTER_A or ENTER_B: operand_a, operand_b, op_sel and the count SHALL be cleared, and the state goes to ENTER_A.
REQ-024 Reserved codes 12 and 13, and any key in ISSUE, SHALL be ignored.
REQ-025 alu_done outside WAIT_RESULT SHALL be ignored.
REQ-026 operand_a, operand_b and op_sel SHALL be stable from ISSUE until alu_done is received.
REQ-027 display_value = operand_a in ENTER_A; operand_b in all other states.
REQ-028 busy SHALL be decoded combinationally from the state; all other outputs SHALL be registered.
REQ-029 Digits SHALL never exceed 9 in any nibble, because inputs 10-15 never enter the shift path.

Reset
REQ-030 When reset=1 asynchronously: state=ENTER_A, operand_a=000, operand_b=000, op_sel=0, start=0, count=0, busy=0, display_value=000.
REQ-031 Reset asserted mid-operation (including ISSUE and WAIT_RESULT) SHALL abort immediately; a start pulse SHALL NOT extend past reset assertion.
REQ-032 After reset deasserts, the first key SHALL be accepted on the first rising edge.

Verification
REQ-033 Keys 1,2,3,ADD,4,5,6,ENTER -> operand_a=0x123, operand_b=0x456, op_sel=0, one start pulse, busy=1.
REQ-034 Keys 9,8,7,6 -> operand_a=0x987, extra digit ignored; then keys CLEAR,5 -> operand_a=0x005.
REQ-035 Keys 1,ADD,SUB,2,ENTER -> op_sel=1, operand_a=0x001, operand_b=0x002; keys 7 and CLEAR during WAIT_RESULT -> no change; alu_done -> ENTER_A, busy=0.
REQ-036 After REQ-035, key 4 -> operand_a=0x004; key 12 -> ignored; ENTER in ENTER_A -> ignored, no start.
REQ-037 Reset pulse in WAIT_RESULT -> all outputs return to REQ-030 values the same cycle; a later alu_done is ignored.
